// File: rtl/fft_pkg.sv
// Shared FFT pipeline definitions: frame geometry, sample width and the
// result-reader state encoding used by the FFT, filter, FFT_inv and reader blocks.
// Ports: none (package only).
package fft_pkg;

    localparam int FFT_N     = 16;
    localparam int FFT_W     = 16;
    localparam int FFT_IDX_W = $clog2(FFT_N);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DRAIN   = 2'd2
    } state_t;

endpackage

// File: rtl/bit_reverse.sv
// Combinational bit-order reversal of an index (bit k of idx lands on bit WIDTH-1-k of rev).
// Ports: idx = natural index in, rev = reversed index out.
// Latency: zero cycles; no state, no backpressure.
module bit_reverse #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] idx,
    output logic [WIDTH-1:0] rev
);

    always_comb begin
        rev = '0;
        for (int k = 0; k < WIDTH; k++) begin
            rev[k] = idx[WIDTH-1-k];
        end
    end

endmodule

// File: rtl/fft_result_reader.sv
// Captures one N-point complex frame from the pipeline on a res_ready rising edge,
// optionally un-bit-reverses it, then replays it in natural order on a valid/ready stream.
// Ports: clk/reset (sync, active-high); res_ready + data_o_r/data_o_i capture input;
//        out_ready/out_valid/out_r/out_i/out_idx/out_last drain stream; busy, frame_err, overrun status.
// Latency: first out_valid the cycle after sample N-1; drain holds outputs stable while out_ready=0.
module fft_result_reader
    import fft_pkg::*;
#(
    parameter int N      = FFT_N,
    parameter int W      = FFT_W,
    parameter bit BITREV = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 res_ready,
    input  logic [W-1:0]         data_o_r,
    input  logic [W-1:0]         data_o_i,
    input  logic                 out_ready,
    output logic [W-1:0]         out_r,
    output logic [W-1:0]         out_i,
    output logic                 out_valid,
    output logic                 out_last,
    output logic [$clog2(N)-1:0] out_idx,
    output logic                 busy,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int             IW   = $clog2(N);
    localparam logic [IW-1:0]  LAST = IW'(N - 1);

    state_t          state, state_next;
    logic            res_ready_q;
    logic            rise;
    logic            wr_en;
    logic            trunc;
    logic            xfer;
    logic [IW-1:0]   wr_cnt, rd_cnt, wr_addr;
    logic [W-1:0]    mem_r [N];
    logic [W-1:0]    mem_i [N];

    // A frame is only recognised on a fresh rising edge, so a level held
    // through reset or through a drain never starts a capture.
    assign rise      = res_ready & ~res_ready_q;
    assign out_valid = (state == DRAIN);
    assign xfer      = out_valid & out_ready;
    assign busy      = (state != IDLE);
    assign out_idx   = rd_cnt;
    assign out_last  = out_valid && (rd_cnt == LAST);
    // Buffer is not cleared by reset, so gate the data outputs to keep them 0 outside DRAIN.
    assign out_r     = out_valid ? mem_r[rd_cnt] : '0;
    assign out_i     = out_valid ? mem_i[rd_cnt] : '0;

    generate
        if (BITREV) begin : g_rev
            bit_reverse #(.WIDTH(IW)) u_rev (
                .idx (wr_cnt),
                .rev (wr_addr)
            );
        end else begin : g_lin
            assign wr_addr = wr_cnt;
        end
    endgenerate

    always_comb begin
        state_next = state;
        wr_en      = 1'b0;
        trunc      = 1'b0;
        case (state)
            IDLE: begin
                // wr_cnt is always 0 here, so the edge-cycle sample lands at address 0.
                if (rise) begin
                    wr_en      = 1'b1;
                    state_next = CAPTURE;
                end
            end
            CAPTURE: begin
                if (res_ready) begin
                    wr_en = 1'b1;
                    if (wr_cnt == LAST) state_next = DRAIN;
                end else begin
                    trunc      = 1'b1;
                    state_next = IDLE;
                end
            end
            DRAIN: begin
                if (xfer && out_last) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            res_ready_q <= 1'b0;
            wr_cnt      <= '0;
            rd_cnt      <= '0;
            frame_err   <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            state       <= state_next;
            res_ready_q <= res_ready;
            frame_err   <= trunc;
            // Full frames wrap wr_cnt back to 0 on their own; truncated ones are rewound.
            if (wr_en)
                wr_cnt <= wr_cnt + 1'b1;
            else if (trunc)
                wr_cnt <= '0;
            if (xfer)
                rd_cnt <= rd_cnt + 1'b1;
            // A frame arriving while draining is dropped; only the flag records it.
            if (out_valid && rise)
                overrun <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !reset) begin
            mem_r[wr_addr] <= data_o_r;
            mem_i[wr_addr] <= data_o_i;
        end
    end

endmodule

// File: doc/fft_result_reader.md
Name: fft_result_reader

Overview:
Consumer end of the FFT → filter → inverse-FFT pipeline output stream. Captures one N-point complex frame from data_o_r/data_o_i when res_ready rises. Optionally undoes bit-reversed ordering, buffers the frame, then replays it in natural order over a valid/ready stream to downstream logic (host interface or DAC path). Flags overrun and truncated frames.

Parameters:
N, 16, points per frame; power of two, 4..256.
W, 16, sample width per component (signed).
BITREV, 1, 1 = incoming frame is bit-reversed and is reordered to natural order; 0 = stored in arrival order.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
res_ready  in  1  pipeline result valid; high for the N consecutive cycles of a frame
data_o_r  in  W  signed real sample from pipeline
data_o_i  in  W  signed imaginary sample from pipeline
out_ready  in  1  downstream accepts a sample
out_r  out  W  signed real sample, natural order
out_i  out  W  signed imaginary sample
out_valid  out  1  out_r/out_i/out_idx valid
out_last  out  1  high with sample index N-1
out_idx  out  log2(N)  natural-order index of current output sample
busy  out  1  state != IDLE
frame_err  out  1  one-cycle pulse: res_ready dropped mid-capture
overrun  out  1  sticky: frame started while draining; cleared only by reset

Behaviour:
- Reset (synchronous, active-high): state=IDLE; counters=0; res_ready_q=0; all outputs 0. Buffer contents are not cleared. Reset mid-capture or mid-drain abandons the frame.
- States: IDLE, CAPTURE, DRAIN.
- IDLE → CAPTURE on a rising edge: res_ready=1 and res_ready_q=0.
  - The sample present in that same cycle is sample 0 and is written.
  - wr_cnt becomes 1.
  - res_ready held high since reset does not start a capture.
- CAPTURE:
  - Each cycle with res_ready=1, write the sample to buf[addr], with addr = BITREV ? bitrev(wr_cnt) : wr_cnt. Then increment wr_cnt.
  - If res_ready=0 before N samples are written: pulse frame_err for one cycle, go to IDLE, nothing is output.
  - Writing sample N-1 moves to DRAIN on the next cycle. res_ready in the cycle after sample N-1 is ignored.
- DRAIN:
  - out_valid=1 combinationally from state.
  - out_r/out_i = buf[rd_cnt]; out_idx = rd_cnt; out_last = (rd_cnt==N-1).
  - Transfer occurs when out_valid && out_ready; rd_cnt then increments.
  - The transfer with out_last → IDLE. rd_cnt wraps to 0.
  - Outputs are held stable while out_ready=0.
- Latency: first out_valid is the cycle after sample N-1 is captured. With out_ready=1 throughout, drain takes exactly N cycles.
- Overrun: a res_ready rising edge during DRAIN sets overrun and that frame is dropped entirely (no capture).
  - After DRAIN completes, the next capture needs a fresh rising edge in IDLE.
  - A rising edge in the same cycle as the final out_last transfer counts as overrun.
- res_ready_q is updated every cycle in every state.
- No arithmetic on samples: values pass bit-exact, sign preserved.

Decomposition:
- Shared package fft_pkg:
  - localparams FFT_N and FFT_W, shared with the FFT, filter and FFT_inv blocks.
  - state typedef (IDLE, CAPTURE, DRAIN).
  - clog2-derived index width.
- Sub-module bit_reverse:
  - parameter WIDTH; purely combinational index reversal.
  - Instantiated for the write address when BITREV=1.
- Buffer is two N×W register arrays inside fft_result_reader; no RAM macro.

Test Plan:
- N=8, BITREV=1: res_ready high 8 cycles, arrival samples r=k*100, i=-k (k=0..7); out_ready=1.
  → out_r sequence 0,400,200,600,100,500,300,700.
  → out_idx 0..7; out_last only at idx 7; drain starts the cycle after the 8th sample.
- N=8, BITREV=0: same stimulus.
  → out_r 0,100,...,700 and out_i 0,-1,...,-7 in order; busy low the cycle after the last transfer.
- Backpressure: toggle out_ready 1,0,0,1 repeatedly during drain.
  → each sample is held stable while stalled; exactly 8 transfers, no duplicates or skips.
- Truncated frame: res_ready high 5 cycles then low.
  → frame_err pulses once on the cycle res_ready is sampled low; state IDLE; out_valid never asserts.
- Overrun: hold out_ready=0 in DRAIN and raise res_ready for 8 cycles.
  → overrun=1 and stays 1; the original frame still drains correctly; the second frame is not output.
- Reset mid-capture after 3 samples, then a full frame of values 1000+k.
  → outputs 0 during and after reset; the next frame drains only values 1000+k; overrun=0, frame_err=0.
